fe_instr_queue: RTL

FE_INSTR_QUEUE -- requirements
Module: fe_instr_queue

---
 rtl/fe_instr_queue.sv | 63 ++++++
 1 files changed

// File: rtl/fe_instr_queue.sv
// Decoded-instruction queue between the front end and dispatch.
// Circular buffer with an explicit occupancy counter; flush and reset empty it in one cycle.
module fe_instr_queue #(
  parameter int DECODED_INSTRUCTION_WIDTH = 32,
  parameter int WIDTH_P = DECODED_INSTRUCTION_WIDTH,
  parameter int DEPTH_P = 4
) (
  input  logic                         clk_i,
  input  logic                         reset_i,
  input  logic                         v_i,
  input  logic [WIDTH_P-1:0]           data_i,
  output logic                         ready_o,
  input  logic                         flush_i,
  output logic                         v_o,
  output logic [WIDTH_P-1:0]           data_o,
  input  logic                         yumi_i,
  output logic [$clog2(DEPTH_P+1)-1:0] count_o
);

  localparam int PTR_W = $clog2(DEPTH_P);
  localparam int CNT_W = $clog2(DEPTH_P+1);

  logic [WIDTH_P-1:0] r_mem [DEPTH_P];
  logic [PTR_W-1:0]   r_head;
  logic [PTR_W-1:0]   r_tail;
  logic [CNT_W-1:0]   r_count;

  logic w_clear;
  logic w_enq;
  logic w_deq;

  // Handshakes see only registered state, so ready_o never depends on yumi_i.
  assign ready_o = (r_count != CNT_W'(DEPTH_P));
  assign v_o     = (r_count != '0);
  assign data_o  = r_mem[r_head];
  assign count_o = r_count;

  assign w_clear = reset_i | flush_i;
  assign w_enq   = v_i & ready_o & ~w_clear;
  assign w_deq   = yumi_i & v_o & ~w_clear;

  always_ff @(posedge clk_i) begin
    if (w_clear) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else begin
      if (w_enq) r_tail <= r_tail + PTR_W'(1);
      if (w_deq) r_head <= r_head + PTR_W'(1);
      r_count <= r_count + CNT_W'(w_enq) - CNT_W'(w_deq);
    end
  end

  // Storage is never cleared; v_o qualifies data_o.
  always_ff @(posedge clk_i) begin
    if (w_enq) r_mem[r_tail] <= data_i;
  end

  a_no_yumi_when_empty : assert property (
    @(posedge clk_i) disable iff (reset_i || flush_i) !(yumi_i && !v_o)
  ) else $warning("fe_instr_queue: yumi_i asserted while queue empty");

endmodule
